tenzo_limit_array: RTL and testbench

Multi-channel strain-gauge limit detector for the hand controller. It supersedes the single-channel fixed-limit tenzo block. It takes real sampled gauge readings for every finger channel and debounces over-limit readings. Each channel raises a registered limit flag with hysteresis or latching release, and tracks a per-channel peak value. The Main control module consumes `o_limit` per finger and `o_limit_any` as a global stop.

---
 rtl/tenzo_pkg.sv | 18 +
 rtl/tenzo_channel.sv | 105 ++++++++++
 rtl/tenzo_limit_array.sv | 58 +++++
 tb/tb_tenzo_limit_array.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tenzo_pkg.sv
// Shared types and helpers for the strain-gauge limit array.
// Channel state encoding and debounce counter sizing.
package tenzo_pkg;

    typedef enum logic [1:0] {
        OK,
        PEND,
        TRIP
    } tenzo_state_e;

    localparam int default_limit = 50;

    // A debounce of N needs to count 0..N inclusive.
    function automatic int dcnt_width(input int deb);
        return (deb < 1) ? 1 : $clog2(deb + 1);
    endfunction

endpackage

// File: rtl/tenzo_channel.sv
// One gauge channel: debounced over-limit FSM with hysteresis
// or latching release, plus a running peak register.
import tenzo_pkg::*;

module tenzo_channel #(
    parameter int W        = 8,
    parameter int LIMIT    = default_limit,
    parameter int HYST     = 4,
    parameter int DEBOUNCE = 3,
    parameter int LATCH    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_sample,
    input  logic         i_press,
    input  logic         i_clear,
    output logic         o_trip_d,
    output logic         o_limit,
    output logic [W-1:0] o_peak
);

    localparam int DW = dcnt_width(DEBOUNCE);
    localparam logic [W-1:0] LIM_W = W'(LIMIT);
    localparam logic [W-1:0] REL_W = W'(LIMIT - HYST);
    localparam logic [DW:0]  DEB_W = (DW+1)'(DEBOUNCE);
    localparam bit LATCH_EN = (LATCH != 0);

    tenzo_state_e state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [W-1:0]  peak_q, peak_d;
    logic [DW:0]   cnt_inc;
    logic          over;
    logic          below;

    assign over    = (i_sample >= LIM_W);
    assign below   = (i_sample < REL_W);
    assign cnt_inc = {1'b0, dcnt_q} + (DW+1)'(1);

    // Next state: press beats clear, clear beats sample handling.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (i_press) begin
            state_d = TRIP;
            dcnt_d  = '0;
        end else if (i_clear) begin
            state_d = OK;
            dcnt_d  = '0;
        end else if (i_valid) begin
            unique case (state_q)
                OK, PEND: begin
                    if (!over) begin
                        state_d = OK;
                        dcnt_d  = '0;
                    end else if (cnt_inc >= DEB_W) begin
                        state_d = TRIP;
                        dcnt_d  = '0;
                    end else begin
                        state_d = PEND;
                        dcnt_d  = cnt_inc[DW-1:0];
                    end
                end
                TRIP: begin
                    if (!LATCH_EN && below) begin
                        state_d = OK;
                        dcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = OK;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // Peak: a clear restarts tracking from the same-cycle sample, if any.
    always_comb begin
        peak_d = peak_q;
        if (i_clear) begin
            peak_d = i_valid ? i_sample : '0;
        end else if (i_valid && (i_sample > peak_q)) begin
            peak_d = i_sample;
        end
    end

    // Channel state, debounce count and peak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OK;
            dcnt_q  <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            peak_q  <= peak_d;
        end
    end

    assign o_trip_d = (state_d == TRIP);
    assign o_limit  = (state_q == TRIP);
    assign o_peak   = peak_q;

endmodule

// File: rtl/tenzo_limit_array.sv
// Multi-channel strain-gauge limit detector: one debounced
// channel per finger plus a global any-limit stop flag.
import tenzo_pkg::*;

module tenzo_limit_array #(
    parameter int N_CH     = 5,
    parameter int W        = 8,
    parameter int LIMIT    = default_limit,
    parameter int HYST     = 4,
    parameter int DEBOUNCE = 3,
    parameter int LATCH    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sample_valid,
    input  logic [N_CH*W-1:0] i_sample,
    input  logic [N_CH-1:0]   i_press,
    input  logic              i_clear,
    output logic [N_CH-1:0]   o_limit,
    output logic              o_limit_any,
    output logic [N_CH*W-1:0] o_peak
);

    logic [N_CH-1:0] trip_d;
    logic            any_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        tenzo_channel #(
            .W        (W),
            .LIMIT    (LIMIT),
            .HYST     (HYST),
            .DEBOUNCE (DEBOUNCE),
            .LATCH    (LATCH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_valid  (i_sample_valid),
            .i_sample (i_sample[k*W +: W]),
            .i_press  (i_press[k]),
            .i_clear  (i_clear),
            .o_trip_d (trip_d[k]),
            .o_limit  (o_limit[k]),
            .o_peak   (o_peak[k*W +: W])
        );
    end

    // Register the OR of next-state flags so it lines up with o_limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |trip_d;
        end
    end

    assign o_limit_any = any_q;

endmodule

// File: tb/tb_tenzo_limit_array.sv
// Directed vector bench for tenzo_limit_array, covering the
// hysteresis variant and a latching variant side by side.
module tb_tenzo_limit_array;

    localparam int N = 5;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           vld;
    logic [N*W-1:0] smp;
    logic [N-1:0]   prs;
    logic           clr;

    logic [N-1:0]   lim_h, lim_l;
    logic           any_h, any_l;
    logic [N*W-1:0] pk_h, pk_l;

    int n_cmp = 0;
    int n_err = 0;

    tenzo_limit_array #(.LATCH(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample_valid (vld),
        .i_sample       (smp),
        .i_press        (prs),
        .i_clear        (clr),
        .o_limit        (lim_h),
        .o_limit_any    (any_h),
        .o_peak         (pk_h)
    );

    tenzo_limit_array #(.LATCH(1)) dut_l (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample_valid (vld),
        .i_sample       (smp),
        .i_press        (prs),
        .i_clear        (clr),
        .o_limit        (lim_l),
        .o_limit_any    (any_l),
        .o_peak         (pk_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           v;
        int             ch;
        int             val;
        logic [N-1:0]   p;
        logic           c;
        logic [N-1:0]   el;
        logic           ea;
        int             pch;
        int             ep;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [N*W-1:0] put(input int ch, input int v);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = W'(v);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int ch, input int val,
                         input logic [N-1:0] p, input logic c);
        @(negedge clk);
        vld = v;
        smp = put(ch, val);
        prs = p;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    function automatic void row(input logic v, input int ch, input int val,
                                input logic [N-1:0] p, input logic c,
                                input logic [N-1:0] el, input logic ea,
                                input int pch, input int ep);
        vec_t r;
        r.v = v; r.ch = ch; r.val = val; r.p = p; r.c = c;
        r.el = el; r.ea = ea; r.pch = pch; r.ep = ep;
        tbl.push_back(r);
    endfunction

    initial begin
        rst_n = 1'b0;
        vld = 1'b0;
        smp = '0;
        prs = '0;
        clr = 1'b0;

        // ch0: below limit, then three at-limit samples trip
        for (int i = 0; i < 5; i++)
            row(1, 0, 49, 5'b0, 0, 5'b00000, 0, 0, 49);
        row(1, 0, 50, 5'b0, 0, 5'b00000, 0, 0, 50);
        row(1, 0, 50, 5'b0, 0, 5'b00000, 0, 0, 50);
        row(1, 0, 50, 5'b0, 0, 5'b00001, 1, 0, 50);
        row(0, 0, 0,  5'b0, 1, 5'b00000, 0, 0, 0);
        // ch1: low sample breaks the count, invalid gap does not
        row(1, 1, 60, 5'b0, 0, 5'b00000, 0, 1, 60);
        row(1, 1, 60, 5'b0, 0, 5'b00000, 0, 1, 60);
        row(1, 1, 10, 5'b0, 0, 5'b00000, 0, 1, 60);
        row(1, 1, 60, 5'b0, 0, 5'b00000, 0, 1, 60);
        row(1, 1, 60, 5'b0, 0, 5'b00000, 0, 1, 60);
        row(0, 1, 99, 5'b0, 0, 5'b00000, 0, 1, 60);
        row(1, 1, 60, 5'b0, 0, 5'b00010, 1, 1, 60);
        // ch2: ch1 releases on its 0 sample; hold on 47,46, release on 45
        row(1, 2, 60, 5'b0, 0, 5'b00000, 0, 2, 60);
        row(1, 2, 60, 5'b0, 0, 5'b00000, 0, 2, 60);
        row(1, 2, 60, 5'b0, 0, 5'b00100, 1, 2, 60);
        row(1, 2, 47, 5'b0, 0, 5'b00100, 1, 2, 60);
        row(1, 2, 46, 5'b0, 0, 5'b00100, 1, 2, 60);
        row(1, 2, 45, 5'b0, 0, 5'b00000, 0, 2, 60);
        // ch4: press with no valid sample, hold while invalid, then release
        row(0, 4, 0, 5'b10000, 0, 5'b10000, 1, 4, 0);
        row(0, 4, 0, 5'b00000, 0, 5'b10000, 1, 4, 0);
        row(1, 4, 0, 5'b00000, 0, 5'b00000, 0, 4, 0);
        // clear with a same-cycle valid sample reloads the peak
        row(1, 0, 30, 5'b0, 1, 5'b00000, 0, 0, 30);

        #3;
        chk("reset_limit", 64'(lim_h), 64'(0));
        chk("reset_any",   64'(any_h), 64'(0));
        chk("reset_peak",  64'(pk_h),  64'(0));
        chk("reset_limit_l", 64'(lim_l), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].ch, tbl[i].val, tbl[i].p, tbl[i].c);
            chk($sformatf("row%0d_limit", i), 64'(lim_h), 64'(tbl[i].el));
            chk($sformatf("row%0d_any", i),   64'(any_h), 64'(tbl[i].ea));
            chk($sformatf("row%0d_peak", i),
                64'(pk_h[tbl[i].pch*W +: W]), 64'(tbl[i].ep));
        end

        // Latching variant: only clear (without press) releases
        drive(0, 0, 0, 5'b0, 1);
        chk("latch_clr_all", 64'(lim_l), 64'(0));
        chk("latch_clr_any", 64'(any_l), 64'(0));
        drive(1, 3, 70, 5'b0, 0);
        drive(1, 3, 70, 5'b0, 0);
        chk("latch_pend", 64'(lim_l), 64'(0));
        drive(1, 3, 70, 5'b0, 0);
        chk("latch_trip", 64'(lim_l), 64'(5'b01000));
        chk("latch_trip_any", 64'(any_l), 64'(1));
        drive(1, 3, 0, 5'b0, 0);
        chk("latch_hold0", 64'(lim_l), 64'(5'b01000));
        chk("latch_peak", 64'(pk_l[3*W +: W]), 64'(70));
        drive(0, 3, 0, 5'b0, 1);
        chk("latch_release", 64'(lim_l), 64'(0));
        chk("latch_rel_any", 64'(any_l), 64'(0));
        chk("latch_peak_clr", 64'(pk_l[3*W +: W]), 64'(0));
        drive(0, 3, 0, 5'b01000, 1);
        chk("latch_press_clr", 64'(lim_l), 64'(5'b01000));
        drive(0, 3, 0, 5'b00000, 1);
        chk("latch_clr_again", 64'(lim_l), 64'(0));

        // Asynchronous reset in the middle of a debounce
        drive(1, 0, 60, 5'b0, 0);
        drive(1, 0, 60, 5'b0, 0);
        drive(0, 1, 0, 5'b00010, 0);
        chk("pre_rst_press", 64'(lim_h), 64'(5'b00010));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_limit", 64'(lim_h), 64'(0));
        chk("rst_any",   64'(any_h), 64'(0));
        chk("rst_peak",  64'(pk_h),  64'(0));
        chk("rst_limit_l", 64'(lim_l), 64'(0));
        @(negedge clk);
        prs = '0;
        rst_n = 1'b1;
        // PEND did not survive reset: one more 60 must not trip
        drive(1, 0, 60, 5'b0, 0);
        chk("post_rst_nopend", 64'(lim_h), 64'(0));
        drive(1, 0, 60, 5'b0, 0);
        drive(1, 0, 60, 5'b0, 0);
        chk("post_rst_trip", 64'(lim_h), 64'(5'b00001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
